dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
REQ-003 SHALL have ports: c_req/c_we  input  1 each  core request / write enable.
REQ-004 SHALL have ports: c_addr  input  9  core word address; c_wdata  input  32  core write data.
REQ-005 SHALL have ports: c_rdata  output  32  core read data; c_ack  output  1  core completion pulse; c_stall  output  1  core hold.
REQ-006 SHALL have ports: d_req, d_we (input 1), d_addr (input 9), d_wdata (input 32), d_rdata (output 32), d_ack (output 1): debug/loader requester, same semantics as core.
REQ-007 SHALL have ports: m_en, m_we (output 1), m_addr (output 9), m_wdata (output 32), m_rdata (input 32): single data-memory port, read data valid the cycle after m_en.
REQ-008 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, RESP; ACCESS and RESP each last exactly one cycle.
REQ-010 In IDLE, if c_req or d_req is high, SHALL select a winner, latch its we/addr/wdata and winner id, and go to ACCESS; otherwise stay in IDLE.
REQ-011 In ACCESS, SHALL drive m_en=1 and m_we/m_addr/m_wdata from the latched values; m_en=0 and m_we=0 in all other states.
REQ-012 In RESP, SHALL assert the winner's ack for exactly one cycle and go to IDLE unconditionally.
REQ-013 For a read, SHALL register m_rdata at the end of ACCESS into the winner's rdata output, valid during the RESP cycle and held until the next read by that requester.
REQ-014 For a write, SHALL leave the winner's rdata unchanged.
REQ-015 Requests SHALL be sampled only in IDLE; req changes during ACCESS/RESP are ignored.
REQ-016 Requester SHALL hold req/we/addr/wdata stable until ack and drop req at the edge ending the ack cycle; a req still high in IDLE starts a new transaction.
REQ-017 c_stall SHALL equal c_req AND NOT c_ack (combinational).
REQ-018 Latency: request sampled in IDLE at cycle N, m_en in N+1, ack in N+2, IDLE again in N+3; peak rate one transaction per 3 cycles.
REQ-019 The losing requester SHALL remain pending with no ack and SHALL be served in a later arbitration.
REQ-020 c_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-021 On rst=0: state=IDLE; m_en, m_we, c_ack, d_ack, busy = 0; m_addr, m_wdata, c_rdata, d_rdata = 0; latched winner = core; round-robin pointer = "last served = debug".
REQ-022 Reset during ACCESS or RESP SHALL abort the transaction with no ack; the requester re-arbitrates after reset release.

Configuration
REQ-023 Macro DMEM_ARB_RR_EN SHALL select the arbitration policy.
REQ-024 Without DMEM_ARB_RR_EN: fixed priority, core wins whenever c_req=1; pointer logic absent.
REQ-025 With DMEM_ARB_RR_EN: when both request, winner is the requester not served last; pointer updates on every grant; single requester always wins.

Verification
REQ-026 Core read: preload mem[0x005]=0xDEADBEEF, c_req=1 c_we=0 c_addr=0x005 in IDLE at N -> m_en=1 at N+1, c_ack=1 and c_rdata=0xDEADBEEF at N+2, c_stall=1 in N..N+1.
REQ-027 Debug write: d_req=1 d_we=1 d_addr=0x1FF d_wdata=0x12345678 -> m_en=m_we=1, m_addr=0x1FF at N+1; d_ack at N+2; d_rdata unchanged; core read of 0x1FF then returns 0x12345678.
REQ-028 Contention, fixed priority: c_req=d_req=1 held continuously (drop only after own ack) -> sequence of acks C, D (D served only after core drops req); no simultaneous acks.
REQ-029 Contention with DMEM_ARB_RR_EN, both requesters re-requesting every IDLE -> acks alternate C, D, C, D starting with C after reset.
REQ-030 Reset mid-op: assert rst=0 during ACCESS of a core write -> outputs zero immediately, no c_ack, busy=0; after release with c_req held, transaction completes 3 cycles later.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates a core and a debug/loader requester onto one data-memory port.
// Define DMEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed core priority.
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [8:0]  c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_ack,
  output logic        c_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [8:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_en,
  output logic        m_we,
  output logic [8:0]  m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_r;
  logic        win_d_r;
  logic        any_req_s;
  logic        grant_d_s;
  logic        sel_we_s;
  logic [8:0]  sel_addr_s;
  logic [31:0] sel_wdata_s;

  assign any_req_s   = c_req | d_req;
  assign c_stall     = c_req & ~c_ack;
  assign sel_we_s    = grant_d_s ? d_we    : c_we;
  assign sel_addr_s  = grant_d_s ? d_addr  : c_addr;
  assign sel_wdata_s = grant_d_s ? d_wdata : c_wdata;

`ifdef DMEM_ARB_RR_EN
  logic last_d_r;

  // Winner select: on contention the requester not served last wins
  always_comb begin
    grant_d_s = 1'b0;
    if (c_req && d_req) begin
      grant_d_s = ~last_d_r;
    end else if (d_req) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
  end

  // Pointer tracks the most recent grant; reset value lets the core go first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && any_req_s) begin
      last_d_r <= grant_d_s;
    end else begin
      last_d_r <= last_d_r;
    end
  end
`else
  // Winner select: core has absolute priority
  always_comb begin
    grant_d_s = 1'b0;
    if (c_req) begin
      grant_d_s = 1'b0;
    end else if (d_req) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
  end
`endif

  // Transaction FSM; m_addr/m_wdata double as the latched request, m_we only during ACCESS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      win_d_r <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= 9'd0;
      m_wdata <= 32'd0;
      c_rdata <= 32'd0;
      d_rdata <= 32'd0;
      c_ack   <= 1'b0;
      d_ack   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          c_ack <= 1'b0;
          d_ack <= 1'b0;
          if (any_req_s) begin
            state_r <= ST_ACCESS;
            win_d_r <= grant_d_s;
            m_en    <= 1'b1;
            m_we    <= sel_we_s;
            m_addr  <= sel_addr_s;
            m_wdata <= sel_wdata_s;
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            busy    <= 1'b0;
          end
        end
        ST_ACCESS: begin
          state_r <= ST_RESP;
          m_en    <= 1'b0;
          m_we    <= 1'b0;
          busy    <= 1'b1;
          c_ack   <= ~win_d_r;
          d_ack   <= win_d_r;
          if (!m_we) begin
            if (win_d_r) begin
              d_rdata <= m_rdata;
            end else begin
              c_rdata <= m_rdata;
            end
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          m_en    <= 1'b0;
          m_we    <= 1'b0;
          c_ack   <= 1'b0;
          d_ack   <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          m_en    <= 1'b0;
          m_we    <= 1'b0;
          c_ack   <= 1'b0;
          d_ack   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, corner sequences and a randomized run against a
// transaction-level reference model of dmem_arbiter.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [8:0]  c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic [31:0] c_rdata, d_rdata;
  logic        c_ack, c_stall, d_ack;
  logic        m_en, m_we, busy;
  logic [8:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  // Memory: read data is presented during the enable cycle and captured by the arbiter at its end
  logic [31:0] mem [0:511];
  logic        pl_en;
  logic [8:0]  pl_addr;
  logic [31:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (m_en && m_we) mem[m_addr] <= m_wdata;
  end
  assign m_rdata = mem[m_addr];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h5A5A_0000 | 32'(i);
  endfunction

  typedef struct {
    logic        dbg;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_c_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;
  vec_t vecs [6];

  task automatic run_vec(input vec_t v);
    if (!v.dbg) begin
      c_req = 1'b1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata;
    end else begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end
    @(negedge clk);
    chk1("vec_busy_n", busy, 1'b0);
    chk1("vec_stall_n", c_stall, !v.dbg);
    @(negedge clk);
    chk1("vec_men_n1", m_en, 1'b1);
    chk1("vec_mwe_n1", m_we, v.we);
    chk32("vec_maddr_n1", {23'd0, m_addr}, {23'd0, v.addr});
    if (v.we) chk32("vec_mwdata_n1", m_wdata, v.wdata);
    chk1("vec_busy_n1", busy, 1'b1);
    chk1("vec_stall_n1", c_stall, !v.dbg);
    @(negedge clk);
    chk1("vec_cack_n2", c_ack, !v.dbg);
    chk1("vec_dack_n2", d_ack, v.dbg);
    chk1("vec_men_n2", m_en, 1'b0);
    chk1("vec_stall_n2", c_stall, 1'b0);
    chk32("vec_crdata_n2", c_rdata, v.exp_c_rdata);
    chk32("vec_drdata_n2", d_rdata, v.exp_d_rdata);
    @(posedge clk); #1;
    c_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk1("vec_busy_n3", busy, 1'b0);
    chk1("vec_ack_n3", c_ack | d_ack, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Reference model state
  int          last_g;
  logic        g_d, g_we, mdl_last_d, c_done, d_done;
  logic [8:0]  g_addr;
  logic [31:0] g_wdata, g_rd, exp_c_rd, exp_d_rd;
  logic        e_men, e_cack, e_dack, e_busy;
  logic [31:0] ref_mem [0:511];
  int          seq [4];
  int          n_ack, n_both;

  initial begin
    rst = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = 9'd0; c_wdata = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 9'd0; d_wdata = 32'd0;
    pl_en = 1'b0; pl_addr = 9'd0; pl_data = 32'd0;

    vecs[0] = '{1'b0, 1'b0, 9'h005, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b1, 9'h1FF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[2] = '{1'b0, 1'b0, 9'h1FF, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b0, 9'h005, 32'h0000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 1'b1, 9'h000, 32'hA5A5_A5A5, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 1'b0, 9'h000, 32'h0000_0000, 32'h1234_5678, 32'hA5A5_A5A5};

    // Preload memory while held in reset
    @(posedge clk); #1;
    pl_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      pl_addr = 9'(i);
      pl_data = (i == 5) ? 32'hDEAD_BEEF : pat(i);
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    @(negedge clk);
    chk1("rst_men", m_en, 1'b0);
    chk1("rst_mwe", m_we, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_acks", c_ack | d_ack, 1'b0);
    chk32("rst_maddr", {23'd0, m_addr}, 32'd0);
    chk32("rst_mwdata", m_wdata, 32'd0);
    chk32("rst_crdata", c_rdata, 32'd0);
    chk32("rst_drdata", d_rdata, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Contention from reset
    do_reset();
    for (int i = 0; i < 4; i++) seq[i] = 0;
    n_ack = 0; n_both = 0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 9'h005;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h000;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      if (c_ack && d_ack) n_both++;
      c_done = c_ack; d_done = d_ack;
      if ((c_ack || d_ack) && n_ack < 4) begin
        seq[n_ack] = c_ack ? 1 : 2;
        n_ack++;
      end
      @(posedge clk); #1;
`ifndef DMEM_ARB_RR_EN
      if (c_done) c_req = 1'b0;
      if (d_done) d_req = 1'b0;
`endif
      if (n_ack == 4) begin
        c_req = 1'b0; d_req = 1'b0;
      end
    end
    c_req = 1'b0; d_req = 1'b0;
    chk32("cont_no_both", 32'(n_both), 32'd0);
    chk32("cont_ack0", 32'(seq[0]), 32'd1);
    chk32("cont_ack1", 32'(seq[1]), 32'd2);
`ifdef DMEM_ARB_RR_EN
    chk32("cont_ack2", 32'(seq[2]), 32'd1);
    chk32("cont_ack3", 32'(seq[3]), 32'd2);
`else
    chk32("cont_count", 32'(n_ack), 32'd2);
`endif
    @(posedge clk); #1;

    // Reset during ACCESS of a core write
    c_req = 1'b1; c_we = 1'b1; c_addr = 9'h0AA; c_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    chk1("rmid_men_access", m_en, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk1("rmid_men", m_en, 1'b0);
    chk1("rmid_mwe", m_we, 1'b0);
    chk1("rmid_busy", busy, 1'b0);
    chk1("rmid_cack", c_ack, 1'b0);
    chk32("rmid_maddr", {23'd0, m_addr}, 32'd0);
    chk32("rmid_mwdata", m_wdata, 32'd0);
    @(negedge clk);
    chk1("rmid_cack_held", c_ack, 1'b0);
    chk32("rmid_mem_untouched", mem[9'h0AA], pat(32'h0AA));
    rst = 1'b1;
    @(negedge clk);
    chk1("rmid_men_retry", m_en, 1'b1);
    chk1("rmid_mwe_retry", m_we, 1'b1);
    chk32("rmid_maddr_retry", {23'd0, m_addr}, 32'h0AA);
    @(negedge clk);
    chk1("rmid_cack_retry", c_ack, 1'b1);
    @(posedge clk); #1;
    c_req = 1'b0;
    @(negedge clk);
    chk32("rmid_mem_written", mem[9'h0AA], 32'hCAFE_F00D);

    // Randomized run against the transaction-level model
    do_reset();
    for (int i = 0; i < 512; i++) ref_mem[i] = mem[i];
    exp_c_rd = 32'd0; exp_d_rd = 32'd0;
    last_g = -10; mdl_last_d = 1'b1;
    g_d = 1'b0; g_we = 1'b0; g_addr = 9'd0; g_wdata = 32'd0; g_rd = 32'd0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ((k == last_g + 2) && !g_we) begin
        if (g_d) exp_d_rd = g_rd;
        else exp_c_rd = g_rd;
      end
      e_men  = (k == last_g + 1);
      e_cack = (k == last_g + 2) && !g_d;
      e_dack = (k == last_g + 2) && g_d;
      e_busy = (k > last_g) && (k < last_g + 3);
      chk1("rnd_men", m_en, e_men);
      chk1("rnd_mwe", m_we, e_men && g_we);
      if (e_men) begin
        chk32("rnd_maddr", {23'd0, m_addr}, {23'd0, g_addr});
        if (g_we) chk32("rnd_mwdata", m_wdata, g_wdata);
      end
      chk1("rnd_cack", c_ack, e_cack);
      chk1("rnd_dack", d_ack, e_dack);
      chk1("rnd_busy", busy, e_busy);
      chk1("rnd_stall", c_stall, c_req && !e_cack);
      chk32("rnd_crdata", c_rdata, exp_c_rd);
      chk32("rnd_drdata", d_rdata, exp_d_rd);
      if ((k >= last_g + 3) && (c_req || d_req)) begin
`ifdef DMEM_ARB_RR_EN
        g_d = (c_req && d_req) ? !mdl_last_d : d_req;
`else
        g_d = !c_req;
`endif
        mdl_last_d = g_d;
        last_g  = k;
        g_we    = g_d ? d_we : c_we;
        g_addr  = g_d ? d_addr : c_addr;
        g_wdata = g_d ? d_wdata : c_wdata;
        if (g_we) ref_mem[g_addr] = g_wdata;
        else g_rd = ref_mem[g_addr];
      end
      c_done = c_ack; d_done = d_ack;
      @(posedge clk); #1;
      if (!c_req || c_done) begin
        c_req   = ($urandom_range(0, 3) != 0);
        c_we    = $urandom_range(0, 1) == 1;
        c_addr  = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
        c_wdata = $urandom;
      end
      if (!d_req || d_done) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
